pool_flatten_engine: RTL and testbench
======================================

POOL_FLATTEN_ENGINE -- requirements
Module: pool_flatten_engine

Interface
REQ-001 Parameter DW, default 20, data word width (two's complement).
REQ-002 Parameter IMG_W, default 64, input image side; power of 2, 4..128.
REQ-003 Parameter CH, default 2, channel count, 1..3.
REQ-004 Parameter AW, default log2(IMG_W*IMG_W), address width.
REQ-005 One clock; reset is asynchronous and active-low; ports clk and reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 ready  input  1  start request, level, sampled only in IDLE.
REQ-009 mode  input  1  0 = max-pool, 1 = average-pool; sampled with ready.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 crd  output  1  memory read strobe.
REQ-012 caddr_rd  output  AW  read address.
REQ-013 cdata_rd  input  DW  read data, valid at the rising edge after the crd cycle.
REQ-014 cwr  output  1  memory write strobe, one cycle per word.
REQ-015 caddr_wr  output  AW  write address.
REQ-016 cdata_wr  output  DW  write data.
REQ-017 csel  output  3  bank select: source ch c = 1+c; pooled ch c = 1+CH+c; flatten = 1+2*CH.

Function
REQ-018 FSM states: IDLE, RD0, RD1, RD2, RD3, ACC, WL1, WFL, DONE.
REQ-019 IDLE with ready=1 at a rising edge: latch mode, clear counters, go to RD0; busy=1 from that edge.
REQ-020 Output pixels (r,c), r,c in 0..IMG_W/2-1, row-major; per pixel, channels 0..CH-1 in order.
REQ-021 RD0..RD3: crd=1, csel=1+ch, caddr_rd = 2r*IMG_W+2c, +1, +IMG_W, +IMG_W+1 respectively.
REQ-022 RD1..ACC capture cdata_rd of the previous read; ACC issues no read (crd=0).
REQ-023 Max mode: signed maximum of the 4 words.
REQ-024 Avg mode: signed sum in DW+2 bits, plus 2, arithmetic shift right 2, truncate to DW.
REQ-025 WL1: cwr=1, csel=1+CH+ch, caddr_wr = r*(IMG_W/2)+c, cdata_wr = result.
REQ-026 WFL: cwr=1, csel=1+2*CH, caddr_wr = (r*(IMG_W/2)+c)*CH+ch, same data.
REQ-027 After WFL: next channel, else next column, else next row, go to RD0; after last (r,c,ch) go to DONE.
REQ-028 Exactly 7 cycles per pixel-channel; no idle cycles between windows.
REQ-029 DONE: busy=0 next edge, return to IDLE; new run only when ready=1 in IDLE.
REQ-030 ready and mode ignored while busy.
REQ-031 crd and cwr never both high; crd=0 and cwr=0 outside listed states; csel=0 in IDLE/DONE.
REQ-032 Counters wrap cleanly at IMG_W/2-1 and CH-1; no address exceeds its bank size.

Reset
REQ-033 reset=0 forces immediately: busy=0, crd=0, cwr=0, csel=0, caddr_rd=0, caddr_wr=0, cdata_wr=0, FSM=IDLE, counters=0.
REQ-034 Reset mid-run aborts with no further writes; previously written words untouched; next run restarts at pixel 0.

Verification
REQ-035 Reset: hold reset=0 with ready=1 -> all outputs 0, busy 0, no strobes.
REQ-036 Max, defaults, src0[a]=a, src1[a]=0xFFFFF-a -> pooled0[0]=0x00041, flatten[0]=0x00041, flatten[1]=0xFFFFF, pooled0[1023]=0x00FFF, flatten[2047]=0xFF041.
REQ-037 Avg: window {1,2,3,4} -> 0x00003; window {-1,-2,-3,-4} -> 0xFFFFE; window {0,0,0,1} -> 0x00000.
REQ-038 Timing, defaults: busy high exactly 14337 cycles; 4096 single-cycle cwr pulses; 8192 crd cycles; crd/cwr never overlap.
REQ-039 Reset at busy cycle 500 -> strobes stop same cycle; after release and ready=1, rerun matches REQ-036 fully.
REQ-040 ready toggled and mode flipped during run -> no effect; CH=1, IMG_W=8 -> csel 1/2/3, 16 pooled and 16 flatten words.

Source files
------------

// File: rtl/pool_flatten_engine_if.sv
// Memory/handshake bundle between the pool/flatten engine and its memory banks.
// Latency: none (wires only).
// Backpressure: none; the engine owns strobe timing and the memory answers one cycle after crd.
//
// Ports (master = engine side):
//   ready, mode      : start request and pool mode into the engine
//   busy             : run in progress
//   crd, caddr_rd    : read strobe/address; cdata_rd returns one cycle later
//   cwr, caddr_wr,
//   cdata_wr         : write strobe/address/data
//   csel             : bank select for the current read or write
interface pool_flatten_engine_if #(
  parameter int DW = 20,
  parameter int AW = 12
);
  logic          ready;
  logic          mode;
  logic          busy;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  modport master (
    input  ready, mode, cdata_rd,
    output busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

  modport slave (
    output ready, mode, cdata_rd,
    input  busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/pool_flatten_engine.sv
// 2x2 max/average pooling of CH image channels, writing each result to a pooled bank and a flattened bank.
// Latency: 7 cycles per pixel-channel (4 reads, accumulate, 2 writes) plus one DONE cycle per run.
// Backpressure: none; memory must return read data the cycle after crd and accept every cwr.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : pool_flatten_engine_if.master (ready/mode in, busy, read and write memory ports, csel)
module pool_flatten_engine #(
  parameter int DW    = 20,
  parameter int IMG_W = 64,
  parameter int CH    = 2,
  parameter int AW    = $clog2(IMG_W*IMG_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  pool_flatten_engine_if.master  bus
);

  localparam int              HW      = $clog2(IMG_W/2);
  localparam logic [HW-1:0]   LAST    = HW'(IMG_W/2 - 1);
  localparam logic [1:0]      CH_LAST = 2'(CH - 1);
  localparam logic [2:0]      POOL_SEL_BASE = 3'(1 + CH);
  localparam logic [2:0]      FLAT_SEL      = 3'(1 + 2*CH);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_ACC, S_WL1, S_WFL, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         r_q, r_d;
  logic [HW-1:0]         c_q, c_d;
  logic [1:0]            ch_q, ch_d;
  logic                  mode_q, mode_d;
  logic signed [DW-1:0]  w0_q, w0_d;
  logic signed [DW-1:0]  w1_q, w1_d;
  logic signed [DW-1:0]  w2_q, w2_d;
  logic [DW-1:0]         res_q, res_d;

  logic                  busy_o, crd_o, cwr_o;
  logic [2:0]            csel_o;
  logic [AW-1:0]         caddr_rd_o, caddr_wr_o;
  logic [DW-1:0]         cdata_wr_o;

  // Source address is {row, col} with row = 2r+dy and col = 2c+dx, so the
  // window corners are simple bit concatenations of the counters.
  logic [AW-1:0]         rd_a0, rd_a1, rd_a2, rd_a3;
  logic [AW-1:0]         pix_idx, flat_addr;
  logic [2:0]            src_sel, pool_sel;
  logic                  last_job;

  assign rd_a0     = AW'({r_q, 1'b0, c_q, 1'b0});
  assign rd_a1     = AW'({r_q, 1'b0, c_q, 1'b1});
  assign rd_a2     = AW'({r_q, 1'b1, c_q, 1'b0});
  assign rd_a3     = AW'({r_q, 1'b1, c_q, 1'b1});
  assign pix_idx   = AW'({r_q, c_q});
  assign flat_addr = pix_idx * AW'(CH) + AW'(ch_q);
  assign src_sel   = 3'd1 + {1'b0, ch_q};
  assign pool_sel  = POOL_SEL_BASE + {1'b0, ch_q};
  assign last_job  = (ch_q == CH_LAST) && (c_q == LAST) && (r_q == LAST);

  // Window reduction; the fourth word is taken straight off the read bus in ACC.
  logic signed [DW-1:0]  w3;
  logic signed [DW-1:0]  max01, max23, max_all;
  logic signed [DW+1:0]  sum_q4;
  logic signed [DW+1:0]  sum_sh;
  logic [DW-1:0]         avg_res;

  assign w3      = $signed(bus.cdata_rd);
  assign max01   = (w0_q > w1_q) ? w0_q : w1_q;
  assign max23   = (w2_q > w3)   ? w2_q : w3;
  assign max_all = (max01 > max23) ? max01 : max23;
  // Round-half-up average: sum in DW+2 bits, +2, arithmetic >>2, keep low DW bits.
  assign sum_q4  = {{2{w0_q[DW-1]}}, w0_q} + {{2{w1_q[DW-1]}}, w1_q}
                 + {{2{w2_q[DW-1]}}, w2_q} + {{2{w3[DW-1]}}, w3}
                 + (DW+2)'(2);
  assign sum_sh  = sum_q4 >>> 2;
  assign avg_res = sum_sh[DW-1:0];

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    res_d      = res_q;
    busy_o     = 1'b0;
    crd_o      = 1'b0;
    cwr_o      = 1'b0;
    csel_o     = 3'd0;
    caddr_rd_o = '0;
    caddr_wr_o = '0;
    cdata_wr_o = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.ready) begin
          mode_d  = bus.mode;
          r_d     = '0;
          c_d     = '0;
          ch_d    = '0;
          state_d = S_RD0;
        end
      end
      S_RD0: begin
        busy_o     = 1'b1;
        crd_o      = 1'b1;
        csel_o     = src_sel;
        caddr_rd_o = rd_a0;
        state_d    = S_RD1;
      end
      S_RD1: begin
        busy_o     = 1'b1;
        crd_o      = 1'b1;
        csel_o     = src_sel;
        caddr_rd_o = rd_a1;
        w0_d       = $signed(bus.cdata_rd);
        state_d    = S_RD2;
      end
      S_RD2: begin
        busy_o     = 1'b1;
        crd_o      = 1'b1;
        csel_o     = src_sel;
        caddr_rd_o = rd_a2;
        w1_d       = $signed(bus.cdata_rd);
        state_d    = S_RD3;
      end
      S_RD3: begin
        busy_o     = 1'b1;
        crd_o      = 1'b1;
        csel_o     = src_sel;
        caddr_rd_o = rd_a3;
        w2_d       = $signed(bus.cdata_rd);
        state_d    = S_ACC;
      end
      S_ACC: begin
        busy_o  = 1'b1;
        res_d   = mode_q ? avg_res : max_all;
        state_d = S_WL1;
      end
      S_WL1: begin
        busy_o     = 1'b1;
        cwr_o      = 1'b1;
        csel_o     = pool_sel;
        caddr_wr_o = pix_idx;
        cdata_wr_o = res_q;
        state_d    = S_WFL;
      end
      S_WFL: begin
        busy_o     = 1'b1;
        cwr_o      = 1'b1;
        csel_o     = FLAT_SEL;
        caddr_wr_o = flat_addr;
        cdata_wr_o = res_q;
        // Channel is the fastest-moving index, then column, then row.
        if (ch_q != CH_LAST) begin
          ch_d = ch_q + 2'd1;
        end else begin
          ch_d = '0;
          if (c_q != LAST) begin
            c_d = c_q + 1'b1;
          end else begin
            c_d = '0;
            if (r_q != LAST) r_d = r_q + 1'b1;
            else             r_d = '0;
          end
        end
        state_d = last_job ? S_DONE : S_RD0;
      end
      S_DONE: begin
        busy_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      ch_q    <= '0;
      mode_q  <= 1'b0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ch_q    <= ch_d;
      mode_q  <= mode_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      res_q   <= res_d;
    end
  end

  // Outputs decode purely from reset-cleared state, so reset silences them at once.
  assign bus.busy     = busy_o;
  assign bus.crd      = crd_o;
  assign bus.cwr      = cwr_o;
  assign bus.csel     = csel_o;
  assign bus.caddr_rd = caddr_rd_o;
  assign bus.caddr_wr = caddr_wr_o;
  assign bus.cdata_wr = cdata_wr_o;

endmodule

// File: tb/tb_pool_flatten_engine.sv
module tb_pool_flatten_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pool_flatten_engine_if #(.DW(20), .AW(12)) bus ();
  pool_flatten_engine_if #(.DW(20), .AW(6))  sbus ();

  pool_flatten_engine #(.DW(20), .IMG_W(64), .CH(2), .AW(12)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  pool_flatten_engine #(.DW(20), .IMG_W(8), .CH(1), .AW(6)) dut_s (
    .clk(clk), .reset(reset), .bus(sbus)
  );

  // Memory models: sources written only by the stimulus, destinations only by the DUTs.
  logic [19:0] src  [2][4096];
  logic [19:0] dst  [8][4096];
  logic [19:0] ssrc [64];
  logic [19:0] sdst [8][64];

  int busy_cnt, crd_cnt, cwr_cnt, ovl_cnt;
  int bank_wr [8];
  int s_busy_cnt, s_crd_cnt, s_bad_sel;
  int s_bank_wr [8];

  always @(posedge clk) begin
    if (bus.busy) busy_cnt <= busy_cnt + 1;
    if (bus.crd && bus.cwr) ovl_cnt <= ovl_cnt + 1;
    if (bus.crd) begin
      crd_cnt <= crd_cnt + 1;
      if (bus.csel == 3'd1 || bus.csel == 3'd2)
        bus.cdata_rd <= src[int'(bus.csel) - 1][bus.caddr_rd];
      else
        bus.cdata_rd <= 20'h0;
    end
    if (bus.cwr) begin
      dst[bus.csel][bus.caddr_wr] <= bus.cdata_wr;
      cwr_cnt <= cwr_cnt + 1;
      bank_wr[bus.csel] <= bank_wr[bus.csel] + 1;
    end
  end

  always @(posedge clk) begin
    if (sbus.busy) s_busy_cnt <= s_busy_cnt + 1;
    if ((sbus.crd || sbus.cwr) && (sbus.csel == 3'd0 || sbus.csel > 3'd3))
      s_bad_sel <= s_bad_sel + 1;
    if (sbus.crd) begin
      s_crd_cnt <= s_crd_cnt + 1;
      sbus.cdata_rd <= (sbus.csel == 3'd1) ? ssrc[sbus.caddr_rd] : 20'h0;
    end
    if (sbus.cwr) begin
      sdst[sbus.csel][sbus.caddr_wr] <= sbus.cdata_wr;
      s_bank_wr[sbus.csel] <= s_bank_wr[sbus.csel] + 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          bank;
    int          addr;
    logic [19:0] exp;
  } vec_t;

  vec_t max_tbl [11];
  vec_t avg_tbl [9];

  task automatic check_max_tbl(input string tag);
    for (int i = 0; i < 11; i++)
      chk({tag, "_", max_tbl[i].name}, 32'(dst[max_tbl[i].bank][max_tbl[i].addr]), 32'(max_tbl[i].exp));
  endtask

  // Starts a run and waits for busy to drop; optionally scrambles ready/mode meanwhile.
  task automatic run_main(input logic m, input bit scramble, input string tag);
    int b0, r0, w0, p0, q0, f0, ov0;
    bit done;
    b0 = busy_cnt; r0 = crd_cnt; w0 = cwr_cnt; ov0 = ovl_cnt;
    p0 = bank_wr[3]; q0 = bank_wr[4]; f0 = bank_wr[5];
    @(negedge clk);
    bus.ready = 1'b1; bus.mode = m;
    @(negedge clk);
    bus.ready = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (scramble && i < 3000) begin
        bus.ready = 1'($urandom_range(0, 1));
        bus.mode  = 1'($urandom_range(0, 1));
      end else begin
        bus.ready = 1'b0;
        bus.mode  = 1'b0;
      end
      if (!bus.busy) begin done = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_finished"}, 32'(done), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'd14337);
    chk({tag, "_crd_cycles"},  32'(crd_cnt - r0),  32'd8192);
    chk({tag, "_cwr_cycles"},  32'(cwr_cnt - w0),  32'd4096);
    chk({tag, "_overlap"},     32'(ovl_cnt - ov0), 32'd0);
    chk({tag, "_pool0_writes"}, 32'(bank_wr[3] - p0), 32'd1024);
    chk({tag, "_pool1_writes"}, 32'(bank_wr[4] - q0), 32'd1024);
    chk({tag, "_flat_writes"},  32'(bank_wr[5] - f0), 32'd2048);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w_snap, k;
    bit done;

    max_tbl[0]  = '{"pool0_0",    3, 0,    20'h00041};
    max_tbl[1]  = '{"flat_0",     5, 0,    20'h00041};
    max_tbl[2]  = '{"flat_1",     5, 1,    20'hFFFFF};
    max_tbl[3]  = '{"pool0_1023", 3, 1023, 20'h00FFF};
    max_tbl[4]  = '{"flat_2047",  5, 2047, 20'hFF041};
    max_tbl[5]  = '{"pool1_0",    4, 0,    20'hFFFFF};
    max_tbl[6]  = '{"pool1_1023", 4, 1023, 20'hFF041};
    max_tbl[7]  = '{"pool0_1",    3, 1,    20'h00043};
    max_tbl[8]  = '{"flat_2",     5, 2,    20'h00043};
    max_tbl[9]  = '{"pool0_32",   3, 32,   20'h000C1};
    max_tbl[10] = '{"flat_64",    5, 64,   20'h000C1};

    avg_tbl[0] = '{"avg_1234",    3, 0,  20'h00003};
    avg_tbl[1] = '{"avg_neg1234", 3, 1,  20'hFFFFE};
    avg_tbl[2] = '{"avg_0001",    3, 2,  20'h00000};
    avg_tbl[3] = '{"avg_1110",    3, 3,  20'h00001};
    avg_tbl[4] = '{"avg_zero",    3, 4,  20'h00000};
    avg_tbl[5] = '{"avg_neg3",    4, 0,  20'hFFFFF};
    avg_tbl[6] = '{"avg_flat0",   5, 0,  20'h00003};
    avg_tbl[7] = '{"avg_flat1",   5, 1,  20'hFFFFF};
    avg_tbl[8] = '{"avg_flat2",   5, 2,  20'hFFFFE};

    for (int a = 0; a < 4096; a++) begin
      src[0][a] = 20'(a);
      src[1][a] = 20'hFFFFF - 20'(a);
    end
    for (int a = 0; a < 64; a++) ssrc[a] = 20'(a);

    // Reset held with a start request pending: everything stays quiet.
    reset = 1'b0;
    bus.ready = 1'b1;  bus.mode = 1'b1;
    sbus.ready = 1'b1; sbus.mode = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_crd",      32'(bus.crd),      32'd0);
    chk("rst_cwr",      32'(bus.cwr),      32'd0);
    chk("rst_csel",     32'(bus.csel),     32'd0);
    chk("rst_caddr_rd", 32'(bus.caddr_rd), 32'd0);
    chk("rst_caddr_wr", 32'(bus.caddr_wr), 32'd0);
    chk("rst_cdata_wr", 32'(bus.cdata_wr), 32'd0);
    chk("rst_strobes",  32'(crd_cnt + cwr_cnt + busy_cnt), 32'd0);
    chk("rst_s_busy",   32'(sbus.busy),    32'd0);
    bus.ready = 1'b0; bus.mode = 1'b0; sbus.ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start", 32'(bus.busy), 32'd0);

    // Max pooling with ready/mode scrambled during the run.
    run_main(1'b0, 1'b1, "max1");
    check_max_tbl("max1");

    // Abort run: first-window timing, then reset at busy cycle 500.
    @(negedge clk);
    bus.ready = 1'b1; bus.mode = 1'b0;
    @(negedge clk);
    bus.ready = 1'b0;
    k = 1;
    chk("seq_rd0_crd",  32'(bus.crd),      32'd1);
    chk("seq_rd0_addr", 32'(bus.caddr_rd), 32'd0);
    chk("seq_rd0_csel", 32'(bus.csel),     32'd1);
    for (int i = 0; i < 5; i++) begin @(negedge clk); k++; end
    chk("seq_wl1_cwr",  32'(bus.cwr),      32'd1);
    chk("seq_wl1_csel", 32'(bus.csel),     32'd3);
    chk("seq_wl1_addr", 32'(bus.caddr_wr), 32'd0);
    chk("seq_wl1_data", 32'(bus.cdata_wr), 32'h41);
    @(negedge clk); k++;
    chk("seq_wfl_csel", 32'(bus.csel),     32'd5);
    @(negedge clk); k++;
    chk("seq_next_ch_csel", 32'(bus.csel), 32'd2);
    while (k < 500) begin @(negedge clk); k++; end
    reset = 1'b0;
    #1;
    chk("abort_crd",  32'(bus.crd),  32'd0);
    chk("abort_cwr",  32'(bus.cwr),  32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    w_snap = cwr_cnt;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_writes", 32'(cwr_cnt - w_snap), 32'd0);
    chk("abort_idle",      32'(bus.busy), 32'd0);
    chk("abort_untouched", 32'(dst[5][2047]), 32'hFF041);
    run_main(1'b0, 1'b0, "rerun");
    check_max_tbl("rerun");

    // Average pooling, rounding and sign corner windows.
    for (int a = 0; a < 4096; a++) begin src[0][a] = 20'h0; src[1][a] = 20'h0; end
    src[0][0] = 20'd1;      src[0][1] = 20'd2;      src[0][64] = 20'd3;      src[0][65] = 20'd4;
    src[0][2] = 20'hFFFFF;  src[0][3] = 20'hFFFFE;  src[0][66] = 20'hFFFFD;  src[0][67] = 20'hFFFFC;
    src[0][69] = 20'd1;
    src[0][6] = 20'd1;      src[0][7] = 20'd1;      src[0][70] = 20'd1;
    src[1][0] = 20'hFFFFD;
    run_main(1'b1, 1'b0, "avg");
    for (int i = 0; i < 9; i++)
      chk(avg_tbl[i].name, 32'(dst[avg_tbl[i].bank][avg_tbl[i].addr]), 32'(avg_tbl[i].exp));

    // Small single-channel instance.
    @(negedge clk);
    sbus.ready = 1'b1; sbus.mode = 1'b0;
    @(negedge clk);
    sbus.ready = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!sbus.busy) begin done = 1'b1; break; end
      @(negedge clk);
    end
    chk("small_finished",   32'(done), 32'd1);
    chk("small_busy",       32'(s_busy_cnt), 32'd113);
    chk("small_crd",        32'(s_crd_cnt), 32'd64);
    chk("small_pool_wr",    32'(s_bank_wr[2]), 32'd16);
    chk("small_flat_wr",    32'(s_bank_wr[3]), 32'd16);
    chk("small_bad_csel",   32'(s_bad_sel), 32'd0);
    chk("small_pool0",      32'(sdst[2][0]),  32'd9);
    chk("small_pool5",      32'(sdst[2][5]),  32'd27);
    chk("small_pool15",     32'(sdst[2][15]), 32'd63);
    chk("small_flat15",     32'(sdst[3][15]), 32'd63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
